// File: rtl/ps2_key_scheduler.sv
// PS/2 scan-code decoder feeding a 4-voice key allocator.
// Decoded make/break bytes allocate or release voices and emit one event each.
module ps2_key_scheduler #(
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        evt_on,
  output logic [1:0]  evt_voice,
  output logic [8:0]  evt_code,
  output logic [3:0]  voice_active,
  output logic [35:0] voice_code,
  output logic        overflow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  localparam int CW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(PREFIX_TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic [2:0]      pause_cnt_q, pause_cnt_d;
  logic            evt_valid_q, evt_valid_d;
  logic            evt_on_q, evt_on_d;
  logic [1:0]      evt_voice_q, evt_voice_d;
  logic [8:0]      evt_code_q, evt_code_d;
  logic [3:0]      voice_active_q, voice_active_d;
  logic [3:0][8:0] voice_code_q, voice_code_d;
  logic            overflow_q, overflow_d;

  // Handshake: an event transfers on any edge where evt_valid and evt_ready
  // are both high; a byte is accepted unless an untaken event is still held.
  logic       accept;
  logic       key_byte;
  logic       is_ext;
  logic       is_break;
  logic [8:0] key_id;
  logic       hit;
  logic [1:0] hit_idx;
  logic       free_found;
  logic [1:0] free_idx;
  logic       ignore_byte;

  assign accept   = byte_valid && !(evt_valid_q && !evt_ready);
  assign is_ext   = (state_q == S_EXT) || (state_q == S_EXT_BRK);
  assign is_break = (state_q == S_BRK) || (state_q == S_EXT_BRK);
  assign key_id   = {is_ext, byte_in};

  always_comb begin
    ignore_byte = 1'b0;
    case (byte_in)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ignore_byte = 1'b1;
      default: ignore_byte = 1'b0;
    endcase
  end

  // Scanning downward leaves the lowest matching index as the winner.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = 2'd0;
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (voice_active_q[i] && (voice_code_q[i] == key_id)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (!voice_active_q[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    to_cnt_d       = to_cnt_q;
    pause_cnt_d    = pause_cnt_q;
    evt_valid_d    = evt_valid_q;
    evt_on_d       = evt_on_q;
    evt_voice_d    = evt_voice_q;
    evt_code_d     = evt_code_q;
    voice_active_d = voice_active_q;
    voice_code_d   = voice_code_q;
    overflow_d     = overflow_q;
    key_byte       = 1'b0;

    if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    if (byte_valid && !accept) begin
      overflow_d = 1'b1;
    end

    if (accept) begin
      to_cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (byte_in == 8'hE0) begin
            state_d = S_EXT;
          end else if (byte_in == 8'hF0) begin
            state_d = S_BRK;
          end else if (byte_in == 8'hE1) begin
            state_d     = S_PAUSE;
            pause_cnt_d = 3'd0;
          end else if (!ignore_byte) begin
            key_byte = 1'b1;
          end
        end
        S_EXT: begin
          if (byte_in == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            key_byte = 1'b1;
          end
        end
        S_BRK, S_EXT_BRK: key_byte = 1'b1;
        S_PAUSE: begin
          // Pause/Break is E1 followed by seven fixed bytes that carry no key.
          if (pause_cnt_q == 3'd6) begin
            state_d     = S_IDLE;
            pause_cnt_d = 3'd0;
          end else begin
            pause_cnt_d = pause_cnt_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (!byte_valid && (state_q != S_IDLE)) begin
      if (to_cnt_q == TO_LAST) begin
        state_d     = S_IDLE;
        to_cnt_d    = '0;
        pause_cnt_d = 3'd0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else if (state_q == S_IDLE) begin
      to_cnt_d = '0;
    end

    if (key_byte) begin
      state_d = S_IDLE;
      if (is_break) begin
        if (hit) begin
          voice_active_d[hit_idx] = 1'b0;
          evt_valid_d             = 1'b1;
          evt_on_d                = 1'b0;
          evt_voice_d             = hit_idx;
          evt_code_d              = key_id;
        end
      end else if (!hit && free_found) begin
        voice_active_d[free_idx] = 1'b1;
        voice_code_d[free_idx]   = key_id;
        evt_valid_d              = 1'b1;
        evt_on_d                 = 1'b1;
        evt_voice_d              = free_idx;
        evt_code_d               = key_id;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      to_cnt_q       <= '0;
      pause_cnt_q    <= 3'd0;
      evt_valid_q    <= 1'b0;
      evt_on_q       <= 1'b0;
      evt_voice_q    <= 2'd0;
      evt_code_q     <= 9'd0;
      voice_active_q <= 4'd0;
      voice_code_q   <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      pause_cnt_q    <= pause_cnt_d;
      evt_valid_q    <= evt_valid_d;
      evt_on_q       <= evt_on_d;
      evt_voice_q    <= evt_voice_d;
      evt_code_q     <= evt_code_d;
      voice_active_q <= voice_active_d;
      voice_code_q   <= voice_code_d;
      overflow_q     <= overflow_d;
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_on       = evt_on_q;
  assign evt_voice    = evt_voice_q;
  assign evt_code     = evt_code_q;
  assign voice_active = voice_active_q;
  assign voice_code   = voice_code_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/ps2_key_scheduler.md
PS2_KEY_SCHEDULER -- requirements
Module: ps2_key_scheduler

Interface
REQ-001 SHALL have parameter PREFIX_TIMEOUT, default 50000, meaning clock cycles a prefix/pause state waits for the next byte before returning to IDLE.
REQ-002 SHALL have port clk  input  1  system clock; all flops on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port byte_valid  input  1  single-cycle pulse: byte_in holds a new received PS/2 byte.
REQ-005 SHALL have port byte_in  input  8  received PS/2 scan-code byte.
REQ-006 SHALL have port evt_valid  output  1  key event pending.
REQ-007 SHALL have port evt_ready  input  1  consumer accepts the event.
REQ-008 SHALL have port evt_on  output  1  1 = note-on (make), 0 = note-off (break).
REQ-009 SHALL have port evt_voice  output  2  voice index 0-3 the event applies to.
REQ-010 SHALL have port evt_code  output  9  key id {extended, scan code}.
REQ-011 SHALL have port voice_active  output  4  bit i = voice i allocated.
REQ-012 SHALL have port voice_code  output  36  voice i key id at bits [9i+8:9i].
REQ-013 SHALL have port overflow  output  1  sticky: a byte was dropped.

Function
REQ-014 SHALL implement decode FSM states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE.
REQ-015 SHALL transition: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; IDLE+E1->PAUSE; any other byte in IDLE/EXT/BRK/EXT_BRK -> decoded as key byte, then IDLE.
REQ-016 SHALL form key id = {1'b1, byte} in EXT/EXT_BRK, {1'b0, byte} in IDLE/BRK; break = state BRK or EXT_BRK.
REQ-017 SHALL in IDLE ignore bytes 00, AA, EE, FA, FE, FF (no event, no state change).
REQ-018 SHALL in PAUSE discard exactly the next 7 bytes (3-bit counter), then return to IDLE.
REQ-019 SHALL on a make: if the key id is held by an active voice, ignore (typematic repeat); else allocate the lowest-index inactive voice, store the id, and emit evt_on=1; if all 4 voices are active, ignore.
REQ-020 SHALL on a break: if an active voice holds the key id, deactivate it and emit evt_on=0 with that voice; else ignore.
REQ-021 SHALL register decode: byte_valid at edge N -> voice_active/voice_code/evt_* updated and evt_valid=1 after edge N+1 (latency 1).
REQ-022 SHALL hold evt_on/evt_voice/evt_code stable while evt_valid=1 and evt_ready=0; transfer occurs at an edge with evt_valid=1 and evt_ready=1; evt_valid clears after that edge unless a new event is produced at the same edge.
REQ-023 SHALL process a byte arriving at the same edge as a transfer normally.
REQ-024 SHALL, when byte_valid=1 while evt_valid=1 and evt_ready=0, drop the byte entirely (FSM, voices unchanged) and set overflow=1 until reset.
REQ-025 SHALL count cycles without byte_valid in EXT/BRK/EXT_BRK/PAUSE; on reaching PREFIX_TIMEOUT go to IDLE; counter clears on every accepted byte and in IDLE.
REQ-026 SHALL update voice state at decode time, independent of event acceptance.

Reset
REQ-027 SHALL on reset=1 asynchronously force state IDLE, counters 0, evt_valid=0, evt_on=0, evt_voice=0, evt_code=0, voice_active=0, voice_code=0, overflow=0, including mid-sequence.

Verification
REQ-028 SHALL cover: ready=1, bytes 1C, F0 1C -> on(voice0, 0x01C), active=0001; then off(voice0, 0x01C), active=0000.
REQ-029 SHALL cover: E0 75, E0 F0 75 -> on(voice0, 0x175) then off(voice0, 0x175); non-extended F0 75 in between produces no event.
REQ-030 SHALL cover: makes 1C 1B 23 2B 34 then 1C -> on events voices 0,1,2,3; 34 and repeated 1C produce no event; active=1111.
REQ-031 SHALL cover: ready=0, 1C then 1B -> event 1C held stable, 1B dropped, overflow=1, voice_active=0001.
REQ-032 SHALL cover: E1 14 77 E1 F0 14 F0 77 then 1C -> no events from pause, then on(voice0, 0x01C).
REQ-033 SHALL cover: F0, PREFIX_TIMEOUT idle cycles, 1C -> on(voice0, 0x01C); separately reset asserted after E0 -> next 75 gives id 0x075.
